// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Contents: ALU operation codes, datapath mux select codes (ALU source A/B,
// PC source), the opcode and funct values this control understands, and the
// control FSM state enumeration.
package mips_ctrl_pkg;

  // ALU operation codes driven on alu_op
  localparam logic [2:0] ALU_NOP = 3'd0;
  localparam logic [2:0] ALU_ADD = 3'd1;
  localparam logic [2:0] ALU_SUB = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_OR  = 3'd4;
  localparam logic [2:0] ALU_XOR = 3'd5;
  localparam logic [2:0] ALU_NOR = 3'd6;
  localparam logic [2:0] ALU_SLL = 3'd7;

  // ALU source A select
  localparam logic [1:0] SRCA_PC    = 2'd0;
  localparam logic [1:0] SRCA_REG   = 2'd1;
  localparam logic [1:0] SRCA_SHAMT = 2'd2;

  // ALU source B select
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;
  localparam logic [1:0] SRCB_BR   = 2'd3;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_EXC    = 2'd3;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct values (IR[5:0])
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_NOR     = 6'b100111;

  typedef enum logic [3:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_R,
    S_WB_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_JUMP,
    S_EXC,
    S_HALT
  } state_t;

endpackage

// File: rtl/mips_alu_op_decode.sv
// Combinational ALU operation decoder.
// Ports:
//   opcode  in  6  IR[31:26]
//   funct   in  6  IR[5:0]
//   alu_op  out 3  ALU operation for the execute step of this instruction
//   legal   out 1  instruction (including R-type funct) is supported
//   trap_en out 1  signed arithmetic whose overflow may raise an exception
// syscall is reported as not legal here: the FSM catches it in DECODE before
// it could ever reach an execute step.
module mips_alu_op_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       legal,
  output logic       trap_en
);

  always_comb begin
    alu_op  = ALU_NOP;
    legal   = 1'b0;
    trap_en = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  begin alu_op = ALU_ADD; trap_en = 1'b1; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUB:  begin alu_op = ALU_SUB; trap_en = 1'b1; end
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLL:  alu_op = ALU_SLL;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin alu_op = ALU_ADD; legal = 1'b1; trap_en = 1'b1; end
      OP_ADDIU: begin alu_op = ALU_ADD; legal = 1'b1; end
      OP_ANDI:  begin alu_op = ALU_AND; legal = 1'b1; end
      OP_ORI:   begin alu_op = ALU_OR;  legal = 1'b1; end
      OP_XORI:  begin alu_op = ALU_XOR; legal = 1'b1; end
      OP_LW, OP_SW:   begin alu_op = ALU_ADD; legal = 1'b1; end
      OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; legal = 1'b1; end
      OP_J:     legal = 1'b1;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM. Sequences fetch, decode, execute, memory and
// writeback over one shared memory port (mem_req held until mem_ready) and
// drives the datapath mux selects and enables.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   opcode, funct         IR fields, stable from DECODE onward
//   equal, overflow       ALU flags (equal meaningful only during SUB)
//   mem_ready             memory completes the pending request this cycle
//   mem_req, mem_we, iord memory request, write qualifier, address select
//   ir_write, pc_write    IR / PC load enables (qualified by mem_ready/equal)
//   pc_src, alu_src_a, ALUSrcB, imm_zext, alu_op   datapath selects
//   reg_write, reg_dst, mem_to_reg                 register file writeback
//   exc_ovf, exc_ill      one-cycle exception pulses (in EXC)
//   halted                high in the terminal HALT state
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter bit EN_OVF_TRAP     = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       equal,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] ALUSrcB,
  output logic       imm_zext,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       exc_ovf,
  output logic       exc_ill,
  output logic       halted
);

  state_t     state_reg, state_next;
  // EXC cause: 1 = overflow, 0 = illegal instruction
  logic       exc_ovf_reg, exc_ovf_next;

  logic [2:0] dec_alu_op;
  logic       dec_legal;
  logic       dec_trap_en;

  mips_alu_op_decode u_dec (
    .opcode  (opcode),
    .funct   (funct),
    .alu_op  (dec_alu_op),
    .legal   (dec_legal),
    .trap_en (dec_trap_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_INIT;
      exc_ovf_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      exc_ovf_reg <= exc_ovf_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    exc_ovf_next = exc_ovf_reg;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    iord         = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = PCSRC_ALU;
    alu_src_a    = SRCA_PC;
    ALUSrcB      = SRCB_REG;
    imm_zext     = 1'b0;
    alu_op       = ALU_NOP;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    exc_ovf      = 1'b0;
    exc_ill      = 1'b0;
    halted       = 1'b0;

    case (state_reg)
      S_INIT: state_next = S_FETCH;

      S_FETCH: begin
        // PC+4 is computed while the instruction read is pending
        mem_req   = 1'b1;
        alu_src_a = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PCSRC_ALU;
          state_next = S_DECODE;
        end
      end

      S_DECODE: begin
        // Branch target computed speculatively into ALUOut
        alu_src_a = SRCA_PC;
        ALUSrcB   = SRCB_BR;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE: state_next = (funct == FN_SYSCALL) ? S_HALT : S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: state_next = S_EXEC_I;
          OP_LW, OP_SW:   state_next = S_MEM_ADDR;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_J:           state_next = S_JUMP;
          default: begin
            if (HALT_ON_ILLEGAL) begin
              state_next = S_HALT;
            end else begin
              state_next   = S_EXC;
              exc_ovf_next = 1'b0;
            end
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a = (funct == FN_SLL) ? SRCA_SHAMT : SRCA_REG;
        ALUSrcB   = SRCB_REG;
        alu_op    = dec_alu_op;
        if (!dec_legal) begin
          if (HALT_ON_ILLEGAL) begin
            state_next = S_HALT;
          end else begin
            state_next   = S_EXC;
            exc_ovf_next = 1'b0;
          end
        end else if (EN_OVF_TRAP && dec_trap_en && overflow) begin
          state_next   = S_EXC;
          exc_ovf_next = 1'b1;
        end else begin
          state_next = S_WB_R;
        end
      end

      S_EXEC_I: begin
        alu_src_a = SRCA_REG;
        ALUSrcB   = SRCB_IMM;
        alu_op    = dec_alu_op;
        imm_zext  = (opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI);
        if (EN_OVF_TRAP && dec_trap_en && overflow) begin
          state_next   = S_EXC;
          exc_ovf_next = 1'b1;
        end else begin
          state_next = S_WB_I;
        end
      end

      S_WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_next = S_FETCH;
      end

      S_WB_I: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_ADDR: begin
        // Address add never traps
        alu_src_a  = SRCA_REG;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALU_ADD;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = S_WB_MEM;
      end

      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_next = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a  = SRCA_REG;
        ALUSrcB    = SRCB_REG;
        alu_op     = ALU_SUB;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = (opcode == OP_BEQ) ? equal : ~equal;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = PCSRC_JUMP;
        state_next = S_FETCH;
      end

      S_EXC: begin
        exc_ovf    = exc_ovf_reg;
        exc_ill    = ~exc_ovf_reg;
        pc_write   = 1'b1;
        pc_src     = PCSRC_EXC;
        state_next = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_next = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control. Two instances share stimulus:
// dut_a uses default parameters, dut_b has HALT_ON_ILLEGAL=1.
// Expected output vectors are pushed when a cycle is driven and popped and
// compared by a monitor on the falling edge of that cycle.
module tb_mips_mc_control;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       imm_zext;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       exc_ovf;
    logic       exc_ill;
    logic       halted;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       equal = 1'b0;
  logic       overflow = 1'b0;
  logic       mem_ready = 1'b0;

  outs_t obs_a, obs_b;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn = 0;

  string tag_q[$];
  outs_t exp_a_q[$];
  outs_t exp_b_q[$];

  always #5 clk = ~clk;

  mips_mc_control #(.EN_OVF_TRAP(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .equal(equal), .overflow(overflow), .mem_ready(mem_ready),
    .mem_req(obs_a.mem_req), .mem_we(obs_a.mem_we), .iord(obs_a.iord),
    .ir_write(obs_a.ir_write), .pc_write(obs_a.pc_write), .pc_src(obs_a.pc_src),
    .alu_src_a(obs_a.src_a), .ALUSrcB(obs_a.src_b), .imm_zext(obs_a.imm_zext),
    .alu_op(obs_a.alu_op), .reg_write(obs_a.reg_write), .reg_dst(obs_a.reg_dst),
    .mem_to_reg(obs_a.mem_to_reg), .exc_ovf(obs_a.exc_ovf), .exc_ill(obs_a.exc_ill),
    .halted(obs_a.halted)
  );

  mips_mc_control #(.EN_OVF_TRAP(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .equal(equal), .overflow(overflow), .mem_ready(mem_ready),
    .mem_req(obs_b.mem_req), .mem_we(obs_b.mem_we), .iord(obs_b.iord),
    .ir_write(obs_b.ir_write), .pc_write(obs_b.pc_write), .pc_src(obs_b.pc_src),
    .alu_src_a(obs_b.src_a), .ALUSrcB(obs_b.src_b), .imm_zext(obs_b.imm_zext),
    .alu_op(obs_b.alu_op), .reg_write(obs_b.reg_write), .reg_dst(obs_b.reg_dst),
    .mem_to_reg(obs_b.mem_to_reg), .exc_ovf(obs_b.exc_ovf), .exc_ill(obs_b.exc_ill),
    .halted(obs_b.halted)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- expected output vectors, written from the control table ----
  function automatic outs_t e_fetch(input logic rdy);
    outs_t e = '0;
    e.mem_req = 1'b1; e.src_b = 2'd1; e.alu_op = 3'd1;
    e.ir_write = rdy; e.pc_write = rdy;
    return e;
  endfunction

  function automatic outs_t e_decode();
    outs_t e = '0;
    e.src_b = 2'd3; e.alu_op = 3'd1;
    return e;
  endfunction

  function automatic outs_t e_exec(input logic [1:0] sa, input logic [1:0] sb,
                                   input logic [2:0] op, input logic zx);
    outs_t e = '0;
    e.src_a = sa; e.src_b = sb; e.alu_op = op; e.imm_zext = zx;
    return e;
  endfunction

  function automatic outs_t e_wb(input logic dst, input logic m2r);
    outs_t e = '0;
    e.reg_write = 1'b1; e.reg_dst = dst; e.mem_to_reg = m2r;
    return e;
  endfunction

  function automatic outs_t e_mem(input logic we);
    outs_t e = '0;
    e.mem_req = 1'b1; e.mem_we = we; e.iord = 1'b1;
    return e;
  endfunction

  function automatic outs_t e_branch(input logic pcw);
    outs_t e = '0;
    e.src_a = 2'd1; e.src_b = 2'd0; e.alu_op = 3'd2; e.pc_src = 2'd1; e.pc_write = pcw;
    return e;
  endfunction

  function automatic outs_t e_jump();
    outs_t e = '0;
    e.pc_write = 1'b1; e.pc_src = 2'd2;
    return e;
  endfunction

  function automatic outs_t e_exc(input logic ovf);
    outs_t e = '0;
    e.pc_write = 1'b1; e.pc_src = 2'd3; e.exc_ovf = ovf; e.exc_ill = ~ovf;
    return e;
  endfunction

  function automatic outs_t e_halt();
    outs_t e = '0;
    e.halted = 1'b1;
    return e;
  endfunction

  // ---- stimulus: called 1 time unit after a rising edge ----
  task automatic cyc(input string tag, input logic rdy, input logic eq, input logic ovf,
                     input outs_t ea, input outs_t eb);
    mem_ready = rdy;
    equal     = eq;
    overflow  = ovf;
    tag_q.push_back(tag);
    exp_a_q.push_back(ea);
    exp_b_q.push_back(eb);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc1(input string tag, input logic rdy, input logic eq, input logic ovf,
                      input outs_t e);
    cyc(tag, rdy, eq, ovf, e, e);
  endtask

  task automatic set_ir(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  // ---- monitor: compares on the falling edge of each driven cycle ----
  initial begin
    string t;
    outs_t ea, eb;
    forever begin
      @(negedge clk);
      if (exp_a_q.size() != 0) begin
        t  = tag_q.pop_front();
        ea = exp_a_q.pop_front();
        eb = exp_b_q.pop_front();
        check_eq({t, "/a"}, 32'(obs_a), 32'(ea));
        check_eq({t, "/b"}, 32'(obs_b), 32'(eb));
        n_txn++;
        $display("txn %0d %s a=%h b=%h", n_txn, t, obs_a, obs_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e0 = '0;

    // reset state
    #3;
    check_eq("reset/a", 32'(obs_a), 32'(e0));
    check_eq("reset/b", 32'(obs_b), 32'(e0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // add $3,$1,$2 : INIT FETCH DECODE EXEC_R WB_R
    set_ir(6'b000000, 6'b100000);
    cyc1("add_init",   1, 0, 0, e0);
    cyc1("add_fetch",  1, 0, 0, e_fetch(1));
    cyc1("add_decode", 1, 0, 0, e_decode());
    cyc1("add_exec",   1, 0, 0, e_exec(2'd1, 2'd0, 3'd1, 0));
    cyc1("add_wb",     1, 0, 0, e_wb(1, 0));

    // sub with overflow traps
    set_ir(6'b000000, 6'b100010);
    cyc1("sub_fetch",  1, 0, 0, e_fetch(1));
    cyc1("sub_decode", 1, 0, 0, e_decode());
    cyc1("sub_exec",   1, 0, 1, e_exec(2'd1, 2'd0, 3'd2, 0));
    cyc1("sub_exc",    1, 0, 0, e_exc(1));

    // addu with overflow writes back
    set_ir(6'b000000, 6'b100001);
    cyc1("addu_fetch",  1, 0, 0, e_fetch(1));
    cyc1("addu_decode", 1, 0, 0, e_decode());
    cyc1("addu_exec",   1, 0, 1, e_exec(2'd1, 2'd0, 3'd1, 0));
    cyc1("addu_wb",     1, 0, 0, e_wb(1, 0));

    // sll uses shamt on source A
    set_ir(6'b000000, 6'b000000);
    cyc1("sll_fetch",  1, 0, 0, e_fetch(1));
    cyc1("sll_decode", 1, 0, 0, e_decode());
    cyc1("sll_exec",   1, 0, 0, e_exec(2'd2, 2'd0, 3'd7, 0));
    cyc1("sll_wb",     1, 0, 0, e_wb(1, 0));

    // nor
    set_ir(6'b000000, 6'b100111);
    cyc1("nor_fetch",  1, 0, 0, e_fetch(1));
    cyc1("nor_decode", 1, 0, 0, e_decode());
    cyc1("nor_exec",   1, 0, 0, e_exec(2'd1, 2'd0, 3'd6, 0));
    cyc1("nor_wb",     1, 0, 0, e_wb(1, 0));

    // addi with overflow traps
    set_ir(6'b001000, 6'd0);
    cyc1("addi_fetch",  1, 0, 0, e_fetch(1));
    cyc1("addi_decode", 1, 0, 0, e_decode());
    cyc1("addi_exec",   1, 0, 1, e_exec(2'd1, 2'd2, 3'd1, 0));
    cyc1("addi_exc",    1, 0, 0, e_exc(1));

    // addiu with overflow writes back
    set_ir(6'b001001, 6'd0);
    cyc1("addiu_fetch",  1, 0, 0, e_fetch(1));
    cyc1("addiu_decode", 1, 0, 0, e_decode());
    cyc1("addiu_exec",   1, 0, 1, e_exec(2'd1, 2'd2, 3'd1, 0));
    cyc1("addiu_wb",     1, 0, 0, e_wb(0, 0));

    // ori zero-extends
    set_ir(6'b001101, 6'd0);
    cyc1("ori_fetch",  1, 0, 0, e_fetch(1));
    cyc1("ori_decode", 1, 0, 0, e_decode());
    cyc1("ori_exec",   1, 0, 0, e_exec(2'd1, 2'd2, 3'd4, 1));
    cyc1("ori_wb",     1, 0, 0, e_wb(0, 0));

    // beq taken / bne not taken with equal=1
    set_ir(6'b000100, 6'd0);
    cyc1("beq_fetch",  1, 1, 0, e_fetch(1));
    cyc1("beq_decode", 1, 1, 0, e_decode());
    cyc1("beq_branch", 1, 1, 0, e_branch(1));
    set_ir(6'b000101, 6'd0);
    cyc1("bne_fetch",  1, 1, 0, e_fetch(1));
    cyc1("bne_decode", 1, 1, 0, e_decode());
    cyc1("bne_branch", 1, 1, 0, e_branch(0));

    // lw with a 3-cycle memory wait; overflow in MEM_ADDR is ignored
    set_ir(6'b100011, 6'd0);
    cyc1("lw_fetch",  1, 0, 0, e_fetch(1));
    cyc1("lw_decode", 1, 0, 0, e_decode());
    cyc1("lw_addr",   1, 0, 1, e_exec(2'd1, 2'd2, 3'd1, 0));
    for (int i = 0; i < 3; i++) cyc1("lw_wait", 0, 0, 0, e_mem(0));
    cyc1("lw_rd",     1, 0, 0, e_mem(0));
    cyc1("lw_wb",     1, 0, 0, e_wb(0, 1));

    // instruction fetch wait, then sw with a 1-cycle wait
    set_ir(6'b101011, 6'd0);
    cyc1("sw_fwait",  0, 0, 0, e_fetch(0));
    cyc1("sw_fwait",  0, 0, 0, e_fetch(0));
    cyc1("sw_fetch",  1, 0, 0, e_fetch(1));
    cyc1("sw_decode", 1, 0, 0, e_decode());
    cyc1("sw_addr",   1, 0, 0, e_exec(2'd1, 2'd2, 3'd1, 0));
    cyc1("sw_wait",   0, 0, 0, e_mem(1));
    cyc1("sw_wr",     1, 0, 0, e_mem(1));

    // j
    set_ir(6'b000010, 6'd0);
    cyc1("j_fetch",  1, 0, 0, e_fetch(1));
    cyc1("j_decode", 1, 0, 0, e_decode());
    cyc1("j_jump",   1, 0, 0, e_jump());

    // unknown R-type funct: EXC on dut_a, HALT on dut_b
    set_ir(6'b000000, 6'b111111);
    cyc1("badfn_fetch",  1, 0, 0, e_fetch(1));
    cyc1("badfn_decode", 1, 0, 0, e_decode());
    cyc1("badfn_exec",   1, 0, 0, e_exec(2'd1, 2'd0, 3'd0, 0));
    cyc("badfn_exc",     1, 0, 0, e_exc(0), e_halt());

    // illegal opcode; dut_b stays halted throughout
    set_ir(6'b111111, 6'd0);
    cyc("badop_fetch",  1, 0, 0, e_fetch(1), e_halt());
    cyc("badop_decode", 1, 0, 0, e_decode(), e_halt());
    cyc("badop_exc",    1, 0, 0, e_exc(0), e_halt());
    cyc("badop_after",  0, 0, 0, e_fetch(0), e_halt());
    cyc("fwait",        0, 0, 0, e_fetch(0), e_halt());

    // async reset during a pending fetch drops mem_req immediately
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_mem_req", 32'(obs_a.mem_req), 32'd0);
    check_eq("rst_async/a", 32'(obs_a), 32'(e0));
    check_eq("rst_async/b", 32'(obs_b), 32'(e0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // syscall after reset halts both
    set_ir(6'b000000, 6'b001100);
    cyc1("sys_init",   1, 0, 0, e0);
    cyc1("sys_fetch",  1, 0, 0, e_fetch(1));
    cyc1("sys_decode", 1, 0, 0, e_decode());
    cyc1("sys_halt",   1, 0, 0, e_halt());
    cyc1("sys_halt2",  1, 0, 0, e_halt());

    // drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4 && exp_a_q.size() != 0; i++) @(posedge clk);
    check_eq("scoreboard_drained", 32'(exp_a_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
